// File: rtl/alu_muldiv_unit.sv
// Iterative signed multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, sign fix-up afterwards, result held in hi/lo.
module alu_muldiv_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter logic [4:0]  OP_MULT = 5'd12,
  parameter logic [4:0]  OP_DIV  = 5'd13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4:0]       alu_operation,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mag;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               fin;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   rem_sh;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] calc_next;
  logic [WIDTH-1:0]   q_fix, r_fix;
  logic [2*WIDTH-1:0] sign_next;
  logic               accept;

  // Magnitudes are unsigned WIDTH bits, so -2^(WIDTH-1) maps to 2^(WIDTH-1) exactly.
  assign a_mag  = op_a[WIDTH-1] ? ('0 - op_a) : op_a;
  assign b_mag  = op_b[WIDTH-1] ? ('0 - op_b) : op_b;
  assign accept = start && (alu_operation == OP_MULT || alu_operation == OP_DIV);

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag : {WIDTH{1'b0}})};
    rem_sh    = {acc[2*WIDTH-2:WIDTH], acc[WIDTH-1]};
    trial     = {1'b0, rem_sh} - {1'b0, mag};
    calc_next = acc;
    if (is_div) begin
      if (trial[WIDTH]) calc_next = {rem_sh, acc[WIDTH-2:0], 1'b0};
      else              calc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      calc_next = {mul_sum, acc[WIDTH-1:1]};
    end
    q_fix = neg_q ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    r_fix = neg_r ? ('0 - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
    if (is_div) sign_next = {r_fix, q_fix};
    else        sign_next = neg_q ? ('0 - acc) : acc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mag    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      fin    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            busy   <= 1'b1;
            cnt    <= '0;
            is_div <= (alu_operation == OP_DIV);
            neg_q  <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            neg_r  <= op_a[WIDTH-1];
            if (alu_operation == OP_DIV && op_b == '0) begin
              // Divide by zero: result preloaded, SIGN only writes it out.
              acc   <= {op_a, {WIDTH{1'b1}}};
              fin   <= 1'b1;
              state <= SIGN;
            end else if (alu_operation == OP_DIV) begin
              acc   <= {{WIDTH{1'b0}}, a_mag};
              mag   <= b_mag;
              fin   <= 1'b0;
              state <= CALC;
            end else begin
              acc   <= {{WIDTH{1'b0}}, b_mag};
              mag   <= a_mag;
              fin   <= 1'b0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc <= calc_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= SIGN;
        end
        SIGN: begin
          // Two edges: sign fix-up first, then publish with the done pulse.
          if (!fin) begin
            acc <= sign_next;
            fin <= 1'b1;
          end else begin
            hi    <= acc[2*WIDTH-1:WIDTH];
            lo    <= acc[WIDTH-1:0];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Self-checking bench for alu_muldiv_unit: directed table, random vectors against
// an arithmetic reference model, and handshake/reset corner sequences.
module tb_alu_muldiv_unit;

  localparam logic [4:0] OP_MULT = 5'd12;
  localparam logic [4:0] OP_DIV  = 5'd13;
  localparam logic [4:0] OP_ADD  = 5'd8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  alu_operation = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  alu_muldiv_unit #(.WIDTH(32), .OP_MULT(OP_MULT), .OP_DIV(OP_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_operation(alu_operation),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: 64-bit signed arithmetic, C-style truncating division.
  task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] mhi, output logic [31:0] mlo);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == OP_DIV) begin
      if (b == 32'd0) begin
        mhi = a;
        mlo = 32'hFFFF_FFFF;
      end else begin
        q = sa / sb;
        r = sa % sb;
        mhi = r[31:0];
        mlo = q[31:0];
      end
    end else begin
      p = sa * sb;
      mhi = p[63:32];
      mlo = p[31:0];
    end
  endtask

  // Present a request for one edge (E0); returns at E0+1.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    alu_operation = op;
    op_a = a;
    op_b = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output int n, output bit ok);
    ok = 1'b0;
    n = 0;
    for (int i = 1; i <= maxc; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = i;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_one(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input int lat);
    int n;
    bit ok;
    issue(op, a, b);
    chk({tag, " busy_at_E0"}, 64'(busy), 64'd1);
    wait_done(60, n, ok);
    chk({tag, " done_seen"}, 64'(ok), 64'd1);
    chk({tag, " latency"}, 64'(n), 64'(lat));
    chk({tag, " hi"}, 64'(hi), 64'(ehi));
    chk({tag, " lo"}, 64'(lo), 64'(elo));
    chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    chk({tag, " done_one_cycle"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n;
    bit ok;
    bit seen;
    logic [31:0] mhi, mlo, h0, l0, ra, rb;
    logic [4:0]  rop;

    vecs[0]  = '{OP_MULT, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 34};
    vecs[1]  = '{OP_DIV,  32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 34};
    vecs[2]  = '{OP_DIV,  32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 34};
    vecs[3]  = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 34};
    vecs[4]  = '{OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 34};
    vecs[5]  = '{OP_DIV,  32'd5,          32'd0,          32'h0000_0005, 32'hFFFF_FFFF, 1};
    vecs[6]  = '{OP_MULT, 32'd0,          32'd12345,      32'h0000_0000, 32'h0000_0000, 34};
    vecs[7]  = '{OP_DIV,  32'd100,        32'd7,          32'h0000_0002, 32'h0000_000E, 34};
    vecs[8]  = '{OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 34};
    vecs[9]  = '{OP_DIV,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_000E, 34};
    vecs[10] = '{OP_MULT, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 34};

    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_one($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
              vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].lat);

    for (int i = 0; i < 24; i++) begin
      rop = ($urandom_range(0, 1) == 0) ? OP_MULT : OP_DIV;
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 15)) - 32'd8;
      model(rop, ra, rb, mhi, mlo);
      run_one($sformatf("rnd%0d", i), rop, ra, rb, mhi, mlo,
              (rop == OP_DIV && rb == 32'd0) ? 1 : 34);
    end

    // Divide by zero followed by a MULT held on start: accepted on the edge after done.
    @(negedge clk);
    start = 1'b1; alu_operation = OP_DIV; op_a = 32'd5; op_b = 32'd0;
    @(posedge clk);
    #1;
    alu_operation = OP_MULT; op_a = 32'd3; op_b = 32'd4;
    @(posedge clk);
    #1;
    chk("dz done", 64'(done), 64'd1);
    chk("dz hi", 64'(hi), 64'd5);
    chk("dz lo", 64'(lo), 64'hFFFF_FFFF);
    chk("dz busy_low", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b busy", 64'(busy), 64'd1);
    chk("b2b done_low", 64'(done), 64'd0);
    wait_done(60, n, ok);
    chk("b2b latency", 64'(n), 64'd34);
    chk("b2b hi", 64'(hi), 64'd0);
    chk("b2b lo", 64'(lo), 64'd12);

    // A MULT request at E10 of a running DIV must be dropped.
    model(OP_DIV, 32'd1000, 32'hFFFF_FFFD, mhi, mlo);
    issue(OP_DIV, 32'd1000, 32'hFFFF_FFFD);
    repeat (9) @(posedge clk);
    issue(OP_MULT, 32'd2, 32'd2);
    wait_done(40, n, ok);
    chk("busy_ignore latency", 64'(n + 10), 64'd34);
    chk("busy_ignore hi", 64'(hi), 64'(mhi));
    chk("busy_ignore lo", 64'(lo), 64'(mlo));
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1'b1;
    end
    chk("busy_ignore no_queue", 64'(seen), 64'd0);

    // Non-mul/div code is ignored entirely.
    h0 = hi;
    l0 = lo;
    issue(OP_ADD, 32'd9, 32'd9);
    seen = busy;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1'b1;
    end
    chk("add ignored", 64'(seen), 64'd0);
    chk("add hold", {hi, lo}, {h0, l0});

    // Reset at E20 of a MULT aborts without a done pulse.
    issue(OP_MULT, 32'd3, 32'd5);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    chk("abort no_done", 64'(seen), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
